// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the IF/MEM memory port arbiter
//
// Purpose: FSM state encodings, grant encodings and the error data word
// returned by a transaction that the watchdog aborts.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS_IF  = 2'd1,
    ARB_BUS_MEM = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } arb_gnt_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-ported memory bus arbiter for the IF and MEM pipeline stages
//
// Purpose: grants the unified memory bus to MEM (strict priority) or IF,
// runs one req/ack transaction with variable slave latency, aborts it with a
// watchdog after TIMEOUT unacknowledged cycles, and returns the result
// through a one-cycle ready pulse to the granted stage.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_kill        fetch request, address, branch flush
//   if_rdata/if_ready             fetched word and its completion pulse
//   mem_ren/mem_wen/mem_addr      load/store request and address
//   mem_wdata                     store data
//   mem_rdata/mem_ready           load data and its completion pulse
//   bus_req/bus_we                bus transaction active / write
//   bus_addr/bus_wdata            latched address and write data
//   bus_rdata/bus_ack             slave read data and completion
//   bus_err                       sticky watchdog timeout flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              kill_q, kill_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [7:0]        cnt_inc;
  logic              done_if;
  logic              done_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= GNT_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      result_q <= result_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    result_d = result_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    // Saturating so a stuck slave can never wrap the watchdog around.
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_ren || mem_wen) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_wen;
          gnt_d   = GNT_MEM;
          cnt_d   = '0;
          state_d = ARB_BUS_MEM;
        end else if (if_req) begin
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
          gnt_d   = GNT_IF;
          cnt_d   = '0;
          state_d = ARB_BUS_IF;
        end
      end

      ARB_BUS_IF, ARB_BUS_MEM: begin
        // A flush only marks the fetch as dead; the bus cycle always finishes.
        if (state_q == ARB_BUS_IF && if_kill) begin
          kill_d = 1'b1;
        end
        if (bus_ack) begin
          result_d = we_q ? '0 : bus_rdata;
          state_d  = ARB_DONE;
        end else begin
          cnt_d = cnt_inc;
          // Compare the incremented count so the abort lands after exactly
          // TIMEOUT bus cycles.
          if (cnt_inc == TIMEOUT_CNT) begin
            err_d    = 1'b1;
            result_d = DATA_W'(ARB_ERR_DATA);
            state_d  = ARB_DONE;
          end
        end
      end

      ARB_DONE: begin
        kill_d  = 1'b0;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (state_q == ARB_BUS_IF) || (state_q == ARB_BUS_MEM);
    bus_we    = (state_q == ARB_BUS_MEM) && we_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    bus_err   = err_q;

    done_if   = (state_q == ARB_DONE) && (gnt_q == GNT_IF);
    done_mem  = (state_q == ARB_DONE) && (gnt_q == GNT_MEM);

    // A kill arriving in DONE itself still suppresses the fetch result.
    if_ready  = done_if && !kill_q && !if_kill;
    if_rdata  = if_ready ? result_q : '0;
    mem_ready = done_mem;
    mem_rdata = done_mem ? result_q : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage MIPS pipeline. It runs a request/acknowledge transaction on the bus with variable slave latency and returns data through a one-cycle ready pulse. The pipeline controller stalls each stage while that stage's request is outstanding. MEM has strict priority. A watchdog ends transactions the slave never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum wait cycles for bus_ack before abort (1..255)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  branch flush: discard the outstanding fetch result
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- mem_ren  in  1  load request, held until mem_ready
- mem_wen  in  1  store request, held until mem_ready (mem_ren & mem_wen is illegal)
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for MEM
- bus_req  out  1  bus transaction active
- bus_we  out  1  write transaction
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched write data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  slave completion, one cycle
- bus_err  out  1  sticky timeout flag

## Operation
- States:
  - IDLE: bus_req=0.
  - BUS_IF: bus_req=1, bus_we=0.
  - BUS_MEM: bus_req=1, bus_we=mem_wen.
  - DONE: bus_req=0. Ready pulses here.
- IDLE arbitration:
  - mem_ren|mem_wen: latch addr, wdata and we; go to BUS_MEM.
  - else if_req: latch if_addr; go to BUS_IF.
  - else stay in IDLE.
- BUS_x with bus_ack=1:
  - Capture bus_rdata into the result register (writes capture 0).
  - Go to DONE.
- BUS_x with no ack: the wait counter increments each cycle. When the counter equals TIMEOUT:
  - Set bus_err.
  - Result = 32'hDEAD_BEEF.
  - Go to DONE.
- DONE:
  - Pulse the ready of the granted requester for one cycle, with rdata driven from the result register.
  - Return to IDLE. No arbitration happens in DONE, so a request still held high from the completed transaction is not reissued.
- if_kill:
  - Asserted in BUS_IF, or in the cycle BUS_IF goes to DONE: set the kill flag.
  - The bus transaction still completes; it is never aborted.
  - In DONE with the kill flag set (or if_kill=1): if_ready stays 0.
  - The kill flag clears in DONE.
  - if_kill in IDLE or BUS_MEM has no effect.
- Latched bus_addr, bus_wdata and bus_we are stable for the whole BUS_x state. Requester input changes after the grant are ignored.
- The wait counter is 8 bits wide, cleared on entry to BUS_x, and saturates.

## Timing
- Reset values: state=IDLE, all outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, if_ready, mem_ready, if_rdata, mem_rdata, bus_err), kill flag 0, counter 0.
- Request seen in IDLE at cycle N:
  - bus_req=1 from N+1.
  - Earliest bus_ack at N+1, giving ready at N+2.
  - Minimum latency is 2 cycles; otherwise latency = ack cycle + 1.
- Back-to-back: the next grant is decided in IDLE at the cycle after DONE. Minimum issue interval is 3 cycles.
- Simultaneous if_req and MEM request in IDLE: MEM is granted. IF is served in the next IDLE.
- Timeout: no ack for TIMEOUT cycles in BUS_x gives DONE at cycle N+1+TIMEOUT.
- Reset mid-transaction: bus_req drops at the next edge, no ready pulse, the latched request is lost. The slave must tolerate a withdrawn req.
- bus_ack outside BUS_x is ignored.

## Structure
- Shared define header holds:
  - the 2-bit state encodings ARB_IDLE, ARB_BUS_IF, ARB_BUS_MEM, ARB_DONE;
  - the grant encoding GNT_IF and GNT_MEM;
  - the constant ARB_ERR_DATA = 32'hDEAD_BEEF.
- The design is a single module with no sub-module. It uses one FSM always-block plus registered latches for address, data, grant, kill flag and counter.

## Test plan
- IF only: if_req, if_addr=0x0000_0040; ack at the 3rd bus cycle with rdata=0x2008_0005 -> if_ready for 1 cycle with that data; bus_req for 3 cycles; no reissue in DONE.
- Contention: if_req and mem_ren (addr 0x100) in the same cycle -> BUS_MEM first, mem_ready with its rdata; then BUS_IF; if_ready after the second ack.
- Store: mem_wen, addr 0x200, wdata 0xCAFE_F00D; slave acks in the first bus cycle -> bus_we=1 with the latched values; mem_ready at request+2.
- Kill: if_kill pulsed in the 2nd cycle of BUS_IF -> bus transaction completes, if_ready stays 0, then arbiter returns to IDLE normally.
- Timeout: TIMEOUT=4, slave never acks -> DONE after 4 wait cycles, mem_rdata=0xDEAD_BEEF, bus_err=1 and stays 1 until rst.
- Reset mid-BUS_MEM -> next cycle bus_req=0, all outputs 0, no ready pulse.
